// File: rtl/k16_fb_pkg.sv
// Shared types and constants for the K16 frame buffer arbiter.
// Holds the RAM geometry, the return-tag and CPU FSM encodings, and the stall counter helper.
package k16_fb_pkg;

  localparam int FB_ADDR_WIDTH = 11;
  localparam int FB_DATA_WIDTH = 16;
  localparam int STALL_WIDTH   = 16;

  typedef enum logic [1:0] {
    TAG_NONE = 2'b00,
    TAG_VID  = 2'b01,
    TAG_CPU  = 2'b10
  } ret_tag_e;

  typedef enum logic [1:0] {
    C_IDLE    = 2'b00,
    C_RD_WAIT = 2'b01,
    C_ACK     = 2'b10
  } cpu_state_e;

  function automatic logic [STALL_WIDTH-1:0] sat_inc(input logic [STALL_WIDTH-1:0] value);
    logic [STALL_WIDTH-1:0] result;
    if (value == {STALL_WIDTH{1'b1}}) begin
      result = value;
    end else begin
      result = value + {{(STALL_WIDTH-1){1'b0}}, 1'b1};
    end
    return result;
  endfunction

endpackage

// File: rtl/k16_fb_arb_stats.sv
// Saturating count of CPU cycles lost to video ownership of the frame buffer port.
// Clear has priority over increment.
module k16_fb_arb_stats
  import k16_fb_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   inc,
  output logic [STALL_WIDTH-1:0] count
);

  logic [STALL_WIDTH-1:0] count_r;

  // Stall counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= {STALL_WIDTH{1'b0}};
    end else if (clear) begin
      count_r <= {STALL_WIDTH{1'b0}};
    end else if (inc) begin
      count_r <= sat_inc(count_r);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/k16_frame_buffer_arbiter.sv
// Shares the single-port frame buffer RAM between the video fetcher (absolute priority)
// and the K16 CPU (req/ack handshake). Optional stall statistics: K16_FB_ARB_STATS_EN.
module k16_frame_buffer_arbiter
  import k16_fb_pkg::*;
#(
  parameter int ADDR_WIDTH = FB_ADDR_WIDTH,
  parameter int DATA_WIDTH = FB_DATA_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   vid_req,
  input  logic [ADDR_WIDTH-1:0]  vid_addr,
  output logic [DATA_WIDTH-1:0]  vid_data,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [ADDR_WIDTH-1:0]  cpu_addr,
  input  logic [DATA_WIDTH-1:0]  cpu_wdata,
  output logic [DATA_WIDTH-1:0]  cpu_rdata,
  output logic                   cpu_ack,
  output logic [ADDR_WIDTH-1:0]  ram_addr,
  output logic [DATA_WIDTH-1:0]  ram_wdata,
  output logic                   ram_we,
  input  logic [DATA_WIDTH-1:0]  ram_rdata,
  input  logic                   stats_clear,
  output logic [STALL_WIDTH-1:0] cpu_stall_cycles
);

  cpu_state_e            state_r;
  cpu_state_e            state_next_s;
  ret_tag_e              tag_r;
  ret_tag_e              tag_next_s;
  logic                  cpu_ack_r;
  logic                  cpu_grant_s;
  logic                  cpu_stall_s;
  logic [DATA_WIDTH-1:0] vid_data_r;
  logic [DATA_WIDTH-1:0] cpu_rdata_r;

  // Port arbitration; reset gating keeps ram_we low while reset is held
  always_comb begin
    cpu_grant_s = 1'b0;
    cpu_stall_s = 1'b0;
    if (reset && !vid_req && (state_r == C_IDLE) && cpu_req && !cpu_ack_r) begin
      cpu_grant_s = 1'b1;
    end else if ((state_r == C_IDLE) && cpu_req && !cpu_ack_r && vid_req) begin
      cpu_stall_s = 1'b1;
    end else begin
      cpu_grant_s = 1'b0;
    end
  end

  // FSM state, return tag and ack registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= C_IDLE;
      tag_r     <= TAG_NONE;
      cpu_ack_r <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      tag_r     <= tag_next_s;
      cpu_ack_r <= (state_next_s == C_ACK);
    end
  end

  // CPU FSM next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      C_IDLE: begin
        if (cpu_grant_s) begin
          state_next_s = cpu_we ? C_ACK : C_RD_WAIT;
        end else begin
          state_next_s = C_IDLE;
        end
      end
      C_RD_WAIT: state_next_s = C_ACK;
      C_ACK:     state_next_s = C_IDLE;
      default:   state_next_s = C_IDLE;
    endcase
  end

  // RAM port drive and return tag; an unowned port idles on the video address
  always_comb begin
    ram_addr   = vid_addr;
    ram_wdata  = {DATA_WIDTH{1'b0}};
    ram_we     = 1'b0;
    tag_next_s = TAG_NONE;
    if (vid_req) begin
      tag_next_s = TAG_VID;
    end else if (cpu_grant_s) begin
      ram_addr   = cpu_addr;
      ram_wdata  = cpu_wdata;
      ram_we     = cpu_we;
      tag_next_s = cpu_we ? TAG_NONE : TAG_CPU;
    end else begin
      tag_next_s = TAG_NONE;
    end
  end

  // Route returning RAM data to the requester recorded in last cycle's tag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vid_data_r  <= {DATA_WIDTH{1'b0}};
      cpu_rdata_r <= {DATA_WIDTH{1'b0}};
    end else begin
      case (tag_r)
        TAG_VID: vid_data_r  <= ram_rdata;
        TAG_CPU: cpu_rdata_r <= ram_rdata;
        default: begin
          vid_data_r  <= vid_data_r;
          cpu_rdata_r <= cpu_rdata_r;
        end
      endcase
    end
  end

  assign vid_data  = vid_data_r;
  assign cpu_rdata = cpu_rdata_r;
  assign cpu_ack   = cpu_ack_r;

`ifdef K16_FB_ARB_STATS_EN
  k16_fb_arb_stats u_stats (
    .clk   (clk),
    .reset (reset),
    .clear (stats_clear),
    .inc   (cpu_stall_s),
    .count (cpu_stall_cycles)
  );
`else
  logic unused_stats_s;
  assign unused_stats_s   = stats_clear | cpu_stall_s;
  assign cpu_stall_cycles = {STALL_WIDTH{1'b0}};
`endif

endmodule
